reg_file_shadow: RTL
====================

Name: reg_file_shadow

Overview:
- Parametrised successor to the accumulator-style register file: 2**D registers of W bits.
- Two combinational read ports (rs and accumulator).
- Primary write steered to rs or to the accumulator, plus a secondary write to the accumulator's companion register.
- Synchronous clear, optional write-through bypass, and a one-cycle save/restore shadow bank for interrupt/context switching.
- Sits between instruction decode and the ALU in the top level, in place of the single-bank file.

Parameters:
- W, 8, data path width in bits.
- D, 4, pointer width; file depth is 2**D.
- ACC, 0, index of the accumulator register; the companion register is (ACC+1) mod 2**D.
- BYPASS, 1, 1 = a read of an address being written this cycle returns the incoming write data; 0 = the read returns the stored value.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- write_en  input  1  primary write enable.
- wr_to_rs  input  1  primary write target: 1 = raddrA (rs), 0 = ACC.
- raddrA  input  D  rs read/write address.
- data_in  input  W  primary write data.
- wr2_en  input  1  secondary write enable; the target is always the companion register (ACC+1).
- data_in2  input  W  secondary write data (high half or carry word).
- save  input  1  copy the entire main bank into the shadow bank.
- restore  input  1  copy the entire shadow bank into the main bank.
- data_outA  output  W  combinational read of registers[raddrA].
- data_outB  output  W  combinational read of registers[ACC].
- shadow_valid  output  1  the shadow bank holds a saved context.

Behaviour:
- Reset (sampled at the rising edge):
  - all main registers = 0; all shadow registers = 0; shadow_valid = 0.
  - Reset overrides every other input in that cycle.
  - Reset asserted mid-sequence (e.g. the cycle after save) discards the saved context.
- Primary write address: waddr = wr_to_rs ? raddrA : ACC. registers[waddr] <= data_in when write_en = 1.
- Secondary write: registers[ACC+1] <= data_in2 when wr2_en = 1.
- Both writes target the same address (waddr == ACC+1): the primary write wins; data_in2 is dropped.
- Reads:
  - Purely combinational, zero latency. Address 0 is readable and writable; there is no hard-wired zero.
  - BYPASS = 1: if an enabled write targets the read address in the current cycle, the output shows that write's data, with the same primary-over-secondary priority. This applies to both ports.
  - BYPASS = 0: outputs show the stored value; the new value appears the cycle after the edge.
  - During a Reset cycle, bypass is suppressed and outputs show stored values.
  - During a valid restore cycle, bypass is suppressed.
- save = 1 (and not Reset, not restore):
  - shadow[i] <= registers[i] for all i, i.e. pre-edge values; same-cycle writes are not captured.
  - shadow_valid <= 1.
  - Same-cycle primary and secondary writes still update the main bank.
- restore = 1 with shadow_valid = 1 (and not Reset):
  - registers[i] <= shadow[i] for all i.
  - All writes in that cycle are dropped.
  - shadow_valid <= 0 (single-use context).
  - Shadow contents are left unchanged.
- restore = 1 with shadow_valid = 0: ignored; normal writes proceed.
- save and restore together with shadow_valid = 1: restore wins; save is ignored that cycle.
- save and restore together with shadow_valid = 0: the save is performed; the restore is ignored.
- Priority per edge: Reset > valid restore > {save, primary write, secondary write}.
- Width rules:
  - Addresses wrap modulo 2**D.
  - ACC+1 with ACC = 2**D-1 wraps to 0.
  - No arithmetic is performed; data is stored verbatim.
- No handshake: every operation completes in one cycle, with no stall.

Test Plan:
- Reset, then write_en=1, wr_to_rs=1, raddrA=5, data_in=8'hA5; next cycle raddrA=5 -> data_outA=8'hA5, data_outB=8'h00.
- BYPASS=1: write_en=1, wr_to_rs=0, data_in=8'h3C -> data_outB=8'h3C in the same cycle; BYPASS=0 build -> 8'h00 that cycle, 8'h3C the next.
- write_en=1, wr_to_rs=1, raddrA=1, data_in=8'h11 and wr2_en=1, data_in2=8'h22 in the same cycle (ACC=0) -> reg1=8'h11.
- Load r0=8'h01, r3=8'h33; assert save together with a write r3<=8'hFF -> shadow_valid=1, r3 reads 8'hFF. Overwrite r0<=8'h77, then restore alone -> r0=8'h01, r3=8'h33, shadow_valid=0. A second restore leaves the registers unchanged.
- Assert save, next cycle Reset=1 -> all reads 0, shadow_valid=0. A following restore has no effect on subsequent writes of 8'h5A.
- save and restore asserted together with shadow_valid=1 -> the main bank takes the old shadow contents and shadow_valid=0. With shadow_valid=0 -> the snapshot is taken and shadow_valid=1.

Source files
------------

// File: rtl/reg_file_shadow.sv
// reg_file_shadow: 2**D x W register file with an accumulator-addressed read
// port, a companion-register secondary write, optional write-through bypass
// and a single-use shadow bank for saving and restoring a whole context.
module reg_file_shadow #(
    parameter int W      = 8,
    parameter int D      = 4,
    parameter int ACC    = 0,
    parameter int BYPASS = 1
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         write_en,
    input  logic         wr_to_rs,
    input  logic [D-1:0] raddrA,
    input  logic [W-1:0] data_in,
    input  logic         wr2_en,
    input  logic [W-1:0] data_in2,
    input  logic         save,
    input  logic         restore,
    output logic [W-1:0] data_outA,
    output logic [W-1:0] data_outB,
    output logic         shadow_valid
);

    localparam int           DEPTH     = 1 << D;
    localparam logic [D-1:0] ACC_ADDR  = D'(ACC);
    localparam logic [D-1:0] COMP_ADDR = D'(ACC + 1);

    logic [W-1:0] regs   [DEPTH];
    logic [W-1:0] shadow [DEPTH];

    logic [D-1:0] waddr;
    logic         do_restore;
    logic         do_save;
    logic         wr1_act;
    logic         wr2_act;

    // Resolve this cycle's operation: reset beats a valid restore, and a valid
    // restore suppresses save and both writes; on an address clash the primary
    // write masks the secondary one, so everything downstream sees one winner.
    always_comb begin
        waddr      = wr_to_rs ? raddrA : ACC_ADDR;
        do_restore = restore && shadow_valid && !Reset;
        do_save    = save && !do_restore && !Reset;
        wr1_act    = write_en && !do_restore && !Reset;
        wr2_act    = wr2_en && !do_restore && !Reset
                     && !(wr1_act && (waddr == COMP_ADDR));
    end

    // Main bank update: clear, wholesale restore, or the two independent writes.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (do_restore) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= shadow[i];
            end
        end else begin
            if (wr2_act) begin
                regs[COMP_ADDR] <= data_in2;
            end
            if (wr1_act) begin
                regs[waddr] <= data_in;
            end
        end
    end

    // Shadow bank snapshots the pre-edge main bank; a restore leaves it intact.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
            end
        end else if (do_save) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= regs[i];
            end
        end
    end

    // Shadow context flag: set by a save, consumed by a restore.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            shadow_valid <= 1'b0;
        end else if (do_restore) begin
            shadow_valid <= 1'b0;
        end else if (do_save) begin
            shadow_valid <= 1'b1;
        end
    end

    // rs read port; the write-activity terms already exclude reset and restore,
    // so bypass is automatically suppressed in those cycles.
    always_comb begin
        data_outA = regs[raddrA];
        if (BYPASS != 0) begin
            if (wr1_act && (waddr == raddrA)) begin
                data_outA = data_in;
            end else if (wr2_act && (COMP_ADDR == raddrA)) begin
                data_outA = data_in2;
            end
        end
    end

    // Accumulator read port with the same bypass priority as the rs port.
    always_comb begin
        data_outB = regs[ACC_ADDR];
        if (BYPASS != 0) begin
            if (wr1_act && (waddr == ACC_ADDR)) begin
                data_outB = data_in;
            end else if (wr2_act && (COMP_ADDR == ACC_ADDR)) begin
                data_outB = data_in2;
            end
        end
    end

endmodule
